// File: rtl/rvc_asap_5pl_fpga_in_sync.sv
// Board-control input conditioning: 2-flop synchronizers, per-channel debounce,
// button polarity normalization and single-cycle press pulses.
module rvc_asap_5pl_fpga_in_sync #(
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic       Clock,
   input  logic       Rst,
   input  logic       RawButton_0,
   input  logic       RawButton_1,
   input  logic [9:0] RawSwitch,
   output logic       Button_0,
   output logic       Button_1,
   output logic       Button_0_Press,
   output logic       Button_1_Press,
   output logic [9:0] Switch
);

   localparam int unsigned CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned SW_W    = 10;
   localparam int unsigned NUM_BTN = 2;
   localparam logic [CW-1:0]      C_MAX   = CW'(DEBOUNCE_CYCLES - 1);
   // Idle (unpressed) pin level, so an unpressed button never looks pressed after reset
   localparam logic [NUM_BTN-1:0] BTN_IDLE = BUTTON_ACTIVE_LOW ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

   logic [NUM_BTN-1:0]         btn_sync1, btn_sync2, btn_s;
   logic [SW_W-1:0]            sw_sync1, sw_sync2;

   logic [NUM_BTN-1:0]         btn_d, btn_d_nxt;
   logic [NUM_BTN-1:0][CW-1:0] btn_c, btn_c_nxt;
   logic [NUM_BTN-1:0]         btn_press, btn_press_nxt;
   logic [SW_W-1:0]            sw_d, sw_d_nxt;
   logic [CW-1:0]              sw_c, sw_c_nxt;

   // Two-flop synchronizers on every raw pin
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         btn_sync1 <= BTN_IDLE;
         btn_sync2 <= BTN_IDLE;
         sw_sync1  <= '0;
         sw_sync2  <= '0;
      end else begin
         btn_sync1 <= {RawButton_1, RawButton_0};
         btn_sync2 <= btn_sync1;
         sw_sync1  <= RawSwitch;
         sw_sync2  <= sw_sync1;
      end
   end

   assign btn_s = BUTTON_ACTIVE_LOW ? ~btn_sync2 : btn_sync2;

   // Debounce: any sample equal to the stable value restarts the qualification count
   always_comb begin
      btn_d_nxt     = btn_d;
      btn_c_nxt     = '0;
      btn_press_nxt = '0;
      sw_d_nxt      = sw_d;
      sw_c_nxt      = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_s[i] != btn_d[i]) begin
            if (btn_c[i] == C_MAX) begin
               btn_d_nxt[i]     = btn_s[i];
               btn_press_nxt[i] = btn_s[i];
            end else begin
               btn_c_nxt[i] = btn_c[i] + CW'(1);
            end
         end
      end
      // Switch vector commits as a whole, taking whatever value is present at commit
      if (sw_sync2 != sw_d) begin
         if (sw_c == C_MAX) begin
            sw_d_nxt = sw_sync2;
         end else begin
            sw_c_nxt = sw_c + CW'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         btn_d     <= '0;
         btn_c     <= '0;
         btn_press <= '0;
         sw_d      <= '0;
         sw_c      <= '0;
      end else begin
         btn_d     <= btn_d_nxt;
         btn_c     <= btn_c_nxt;
         btn_press <= btn_press_nxt;
         sw_d      <= sw_d_nxt;
         sw_c      <= sw_c_nxt;
      end
   end

   assign Button_0       = btn_d[0];
   assign Button_1       = btn_d[1];
   assign Button_0_Press = btn_press[0];
   assign Button_1_Press = btn_press[1];
   assign Switch         = sw_d;

endmodule

// File: tb/tb_rvc_asap_5pl_fpga_in_sync.sv
// Scoreboard bench for rvc_asap_5pl_fpga_in_sync: directed test-plan scenarios
// followed by randomized pin activity, checked against a run-length debounce model.
module tb_rvc_asap_5pl_fpga_in_sync;

   localparam int unsigned DC = 4;

   typedef struct packed {
      logic       b0;
      logic       b1;
      logic       p0;
      logic       p1;
      logic [9:0] sw;
   } exp_t;

   logic       clk = 1'b0;
   logic       Rst = 1'b1;
   logic       RawButton_0 = 1'b1;
   logic       RawButton_1 = 1'b1;
   logic [9:0] RawSwitch = '0;
   logic       Button_0, Button_1, Button_0_Press, Button_1_Press;
   logic [9:0] Switch;

   int errors = 0;
   int checks = 0;

   exp_t sb[$];
   exp_t mon_e;

   // Reference model: normalized samples (1 = pressed) delayed two cycles, then
   // each channel commits after DC consecutive samples that differ from its value.
   logic [11:0] m_p1, m_p2;
   logic        m_d0, m_d1;
   logic [9:0]  m_dsw;
   int          run0, run1, runsw;

   rvc_asap_5pl_fpga_in_sync #(
      .DEBOUNCE_CYCLES  (DC),
      .BUTTON_ACTIVE_LOW(1'b1)
   ) dut (
      .Clock         (clk),
      .Rst           (Rst),
      .RawButton_0   (RawButton_0),
      .RawButton_1   (RawButton_1),
      .RawSwitch     (RawSwitch),
      .Button_0      (Button_0),
      .Button_1      (Button_1),
      .Button_0_Press(Button_0_Press),
      .Button_1_Press(Button_1_Press),
      .Switch        (Switch)
   );

   always #5 clk = ~clk;

   function automatic exp_t dut_out();
      exp_t o;
      o.b0 = Button_0;
      o.b1 = Button_1;
      o.p0 = Button_0_Press;
      o.p1 = Button_1_Press;
      o.sw = Switch;
      return o;
   endfunction

   task automatic chk(input string name, input exp_t got, input exp_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got b0=%b b1=%b p0=%b p1=%b sw=%h, expected b0=%b b1=%b p0=%b p1=%b sw=%h",
                  name, $time, got.b0, got.b1, got.p0, got.p1, got.sw,
                  exp.b0, exp.b1, exp.p0, exp.p1, exp.sw);
      end
   endtask

   task automatic model_reset();
      m_p1 = '0; m_p2 = '0;
      m_d0 = 1'b0; m_d1 = 1'b0; m_dsw = '0;
      run0 = 0; run1 = 0; runsw = 0;
   endtask

   // One clock of stimulus: drive pins at the falling edge, predict the
   // outputs after the next rising edge and queue the prediction.
   task automatic cycle(input logic rst, input logic b0, input logic b1, input logic [9:0] sw);
      exp_t        e;
      logic [11:0] s;
      logic        fell;
      @(negedge clk);
      fell        = Rst && !rst;
      Rst         = rst;
      RawButton_0 = b0;
      RawButton_1 = b1;
      RawSwitch   = sw;
      e = '0;
      if (!rst) begin
         model_reset();
         if (fell) begin
            #1;
            chk("async_reset", dut_out(), exp_t'(0));
         end
      end else begin
         s    = m_p2;
         m_p2 = m_p1;
         m_p1 = {sw, ~b1, ~b0};
         if (s[0] == m_d0) run0 = 0;
         else begin
            run0++;
            if (run0 == DC) begin m_d0 = s[0]; run0 = 0; e.p0 = m_d0; end
         end
         if (s[1] == m_d1) run1 = 0;
         else begin
            run1++;
            if (run1 == DC) begin m_d1 = s[1]; run1 = 0; e.p1 = m_d1; end
         end
         if (s[11:2] == m_dsw) runsw = 0;
         else begin
            runsw++;
            if (runsw == DC) begin m_dsw = s[11:2]; runsw = 0; end
         end
      end
      e.b0 = m_d0;
      e.b1 = m_d1;
      e.sw = m_dsw;
      sb.push_back(e);
   endtask

   // Monitor: the DUT presents a fresh output set after every rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("outputs", dut_out(), mon_e);
         end
      end
   end

   initial begin
      logic       rb0, rb1;
      logic [9:0] rsw;
      int         len;
      logic [1:0] bounce [8];
      model_reset();

      // Reset with unpressed button and all switches up, then release
      repeat (3) cycle(1'b0, 1'b1, 1'b1, 10'h3FF);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h3FF);

      // Clean press and release on button 0
      repeat (10) cycle(1'b1, 1'b0, 1'b1, 10'h3FF);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h3FF);

      // Bounce on button 1: 1,0,1,0,0,0,0,0 then held pressed, then released
      bounce = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, bounce[i][0], 10'h3FF);
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h3FF);

      // Switch atomicity: 0 -> 001 -> (2 cycles later) 201
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h000);
      repeat (2) cycle(1'b1, 1'b1, 1'b1, 10'h001);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h201);

      // Reset in the middle of a button-0 qualification
      repeat (4) cycle(1'b1, 1'b0, 1'b1, 10'h201);
      repeat (2) cycle(1'b0, 1'b0, 1'b1, 10'h201);
      repeat (10) cycle(1'b1, 1'b0, 1'b1, 10'h201);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h201);

      // Simultaneous events on all three channels
      repeat (10) cycle(1'b1, 1'b0, 1'b0, 10'h155);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 10'h2AA);

      // Randomized pin activity with variable hold times and rare resets
      rb0 = 1'b1; rb1 = 1'b1; rsw = 10'h2AA;
      for (int seg = 0; seg < 80; seg++) begin
         len = int'($urandom_range(1, 8));
         if ($urandom_range(0, 1) == 1) rb0 = ~rb0;
         if ($urandom_range(0, 1) == 1) rb1 = ~rb1;
         if ($urandom_range(0, 2) == 0) rsw = 10'($urandom);
         if ($urandom_range(0, 24) == 0) cycle(1'b0, rb0, rb1, rsw);
         repeat (len) cycle(1'b1, rb0, rb1, rsw);
      end
      repeat (12) cycle(1'b1, rb0, rb1, rsw);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
